dmem_arbiter: RTL and testbench

- Shares the single-port, synchronous-read data memory between two requesters: the pipeline MEM stage (cpu_*) and the debug/loader port (dbg_*).
- Arbitrates each cycle and drives the memory command pins.
- Tracks the owner of each read so the one-cycle-later read data is routed back to the correct requester.
- Bounds debug starvation with a wait counter and flags out-of-range accesses.

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (cpu/dbg) arbiter for a single-port sync-read data memory
// Optional perf counters: define DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int MEM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_err,
  output logic                  Mem_W_En,
  output logic                  Mem_R_En,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  input  logic [DATA_WIDTH-1:0] mem_readData
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_cpu_cnt,
  output logic [31:0]           perf_dbg_cnt,
  output logic [31:0]           perf_conflict_cnt
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]            wait_cnt;
  logic                  cpu_win;
  logic                  dbg_win;
  logic                  any_win;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  oor;
  logic                  cpu_rsp_q;
  logic                  cpu_err_q;
  logic                  dbg_rsp_q;
  logic                  dbg_err_q;

  // cpu has priority unless dbg has been starved for STARVE_LIMIT cycles
  always_comb begin
    dbg_win   = !Reset && dbg_req && (!cpu_req || wait_cnt == LIMIT);
    cpu_win   = !Reset && cpu_req && !dbg_win;
    any_win   = cpu_win || dbg_win;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (dbg_win) begin
      win_we    = dbg_we;
      win_addr  = dbg_addr;
      win_wdata = dbg_wdata;
    end else if (cpu_win) begin
      win_we    = cpu_we;
      win_addr  = cpu_addr;
      win_wdata = cpu_wdata;
    end
    oor = any_win && (32'(win_addr) >= 32'(MEM_SIZE));
  end

  assign cpu_gnt       = cpu_win;
  assign dbg_gnt       = dbg_win;
  assign mem_address   = win_addr;
  assign mem_writeData = win_wdata;
  assign Mem_W_En      = any_win && win_we && !oor;
  assign Mem_R_En      = any_win && !win_we && !oor;

  // Response bookkeeping: owner of the read and its range flag, one cycle behind the grant
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt  <= '0;
      cpu_rsp_q <= 1'b0;
      cpu_err_q <= 1'b0;
      dbg_rsp_q <= 1'b0;
      dbg_err_q <= 1'b0;
    end else begin
      if (!dbg_req || dbg_win)
        wait_cnt <= '0;
      else if (wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + 8'd1;
      cpu_rsp_q <= cpu_win && !win_we;
      cpu_err_q <= cpu_win && oor;
      dbg_rsp_q <= dbg_win && !win_we;
      dbg_err_q <= dbg_win && oor;
    end
  end

  assign cpu_rvalid = cpu_rsp_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = (cpu_rsp_q && !cpu_err_q) ? mem_readData : '0;
  assign dbg_rvalid = dbg_rsp_q;
  assign dbg_err    = dbg_err_q;
  assign dbg_rdata  = (dbg_rsp_q && !dbg_err_q) ? mem_readData : '0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      perf_cpu_cnt      <= '0;
      perf_dbg_cnt      <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (cpu_win)
        perf_cpu_cnt <= perf_cpu_cnt + 32'd1;
      if (dbg_win)
        perf_dbg_cnt <= perf_dbg_cnt + 32'd1;
      if (cpu_req && dbg_req)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int AW = 10, DW = 32, MSIZE = 1000, LIM = 4;

  logic clk = 1'b0;
  logic Reset;
  logic cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_address;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_writeData, mem_readData;
  logic cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err, Mem_W_En, Mem_R_En;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_cnt, perf_dbg_cnt, perf_conflict_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MSIZE), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .Mem_W_En(Mem_W_En), .Mem_R_En(Mem_R_En), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_cnt(perf_cpu_cnt), .perf_dbg_cnt(perf_dbg_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  // Physical memory attached to the arbiter
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (Mem_W_En) mem[mem_address] <= mem_writeData;
    if (Mem_R_En) mem_readData <= mem[mem_address];
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [0:1023];
  int m_wait, p_cpu, p_dbg, p_conf;
  logic m_cv, m_ce, m_dv, m_de;
  logic [DW-1:0] m_cd, m_dd;
  logic smp_cg, smp_dg, smp_w, smp_r;

  task automatic model_clear();
    m_wait = 0; p_cpu = 0; p_dbg = 0; p_conf = 0;
    m_cv = 0; m_ce = 0; m_dv = 0; m_de = 0; m_cd = '0; m_dd = '0;
  endtask

  // One clock cycle: called at posedge+1, returns at next posedge+1
  task automatic cyc(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                     input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                     output logic gc, output logic gd);
    logic we, o, any;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #3;
    gd = dr && (!cr || m_wait >= LIM);
    gc = cr && !gd;
    any = gc || gd;
    we = gd ? dw : cw;
    a  = gd ? da : ca;
    d  = gd ? dd : cd;
    o  = any && (int'(a) >= MSIZE);
    smp_cg = cpu_gnt; smp_dg = dbg_gnt; smp_w = Mem_W_En; smp_r = Mem_R_En;
    chk("cpu_gnt", cpu_gnt, gc);
    chk("dbg_gnt", dbg_gnt, gd);
    chk("mem_w_en", Mem_W_En, any && we && !o);
    chk("mem_r_en", Mem_R_En, any && !we && !o);
    if (any && !o) chk("mem_address", mem_address, a);
    if (!any) chk("mem_address_idle", mem_address, 0);
    if (any && we && !o) chk("mem_wdata", mem_writeData, d);
    chk("cpu_rvalid", cpu_rvalid, m_cv);
    chk("cpu_err", cpu_err, m_ce);
    chk("cpu_rdata", cpu_rdata, m_cd);
    chk("dbg_rvalid", dbg_rvalid, m_dv);
    chk("dbg_err", dbg_err, m_de);
    chk("dbg_rdata", dbg_rdata, m_dd);
    m_cv = gc && !we; m_ce = gc && o; m_cd = (gc && !we && !o) ? ref_mem[a] : '0;
    m_dv = gd && !we; m_de = gd && o; m_dd = (gd && !we && !o) ? ref_mem[a] : '0;
    if (any && we && !o) ref_mem[a] = d;
    m_wait = (dr && !gd) ? ((m_wait + 1 > LIM) ? LIM : m_wait + 1) : 0;
    p_cpu += int'(gc); p_dbg += int'(gd); p_conf += int'(cr && dr);
    @(posedge clk); #1;
  endtask

  task automatic chk_perf(input string tag);
`ifdef DMEM_ARB_PERF_EN
    chk({tag, "_perf_cpu"}, perf_cpu_cnt, p_cpu);
    chk({tag, "_perf_dbg"}, perf_dbg_cnt, p_dbg);
    chk({tag, "_perf_conflict"}, perf_conflict_cnt, p_conf);
`endif
  endtask

  typedef struct {
    logic cr, cw; logic [AW-1:0] ca; logic [DW-1:0] cd;
    logic dr, dw; logic [AW-1:0] da; logic [DW-1:0] dd;
    logic egc, egd, ew, er;
  } vec_t;
  vec_t tbl [10];

  logic gc, gd;
  logic pc_req, pc_we, pd_req, pd_we;
  logic [AW-1:0] pc_a, pd_a;
  logic [DW-1:0] pc_d, pd_d;

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hA5A50001; ref_mem[5] = 32'hA5A50001;
    model_clear();

    //                cr cw ca    cd            dr dw da    dd            gc gd w  r
    tbl[0] = '{1'b1, 1'b0, 10'd5,    32'h0,        1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 10'd3,    32'h1234,     1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 10'd3,    32'h0,        1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b1, 10'd7,    32'hDEAD0007, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 10'd1,    32'h0,        1'b1, 1'b0, 10'd2,    32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 10'd2,    32'h0,        1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 10'd1010, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 10'd999,  32'h55,       1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 10'd1000, 32'h0,        1'b0, 1'b0, 10'd0,    32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 10'd0,    32'h0,        1'b0, 1'b0, 10'd0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with a pending cpu read request
    Reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    #2;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_mem_r_en", Mem_R_En, 0);
    chk("rst_mem_w_en", Mem_W_En, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_err", dbg_err, 0);
    @(posedge clk); @(posedge clk); #1;
    Reset = 1'b0;
    chk_perf("rst");

    // Directed table: command side against the table, responses against the model
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd, gc, gd);
      chk($sformatf("tbl%0d_cpu_gnt", i), smp_cg, tbl[i].egc);
      chk($sformatf("tbl%0d_dbg_gnt", i), smp_dg, tbl[i].egd);
      chk($sformatf("tbl%0d_w_en", i), smp_w, tbl[i].ew);
      chk($sformatf("tbl%0d_r_en", i), smp_r, tbl[i].er);
    end

    // Starvation: both held, dbg wins every fifth cycle
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b0, 10'd8, '0, 1'b1, 1'b0, 10'd9, '0, gc, gd);
      chk($sformatf("starve%0d_dbg_gnt", i), smp_dg, (i % 5) == 4);
    end

    // Alternating reads on the two ports
    for (int i = 0; i < 8; i++)
      cyc(i % 2 == 0, 1'b0, 10'd1, '0, i % 2 == 1, 1'b0, 10'd2, '0, gc, gd);
    cyc(1'b1, 1'b1, 10'd4, 32'hBEEF, 1'b0, 1'b0, 10'd0, '0, gc, gd);
    cyc(1'b0, 1'b0, 10'd0, '0, 1'b1, 1'b0, 10'd4, '0, gc, gd);
    cyc(1'b1, 1'b0, 10'd4, '0, 1'b0, 1'b0, 10'd0, '0, gc, gd);
    cyc(1'b1, 1'b1, 10'd4, 32'hF00D, 1'b0, 1'b0, 10'd0, '0, gc, gd);
    cyc(1'b0, 1'b0, 10'd0, '0, 1'b0, 1'b0, 10'd0, '0, gc, gd);
    chk_perf("mid");

    // Reset arriving while a read response is pending
    cyc(1'b1, 1'b0, 10'd6, '0, 1'b1, 1'b0, 10'd7, '0, gc, gd);
    cyc(1'b1, 1'b0, 10'd6, '0, 1'b1, 1'b0, 10'd7, '0, gc, gd);
    Reset = 1'b1;
    #1;
    chk("rst_pend_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_pend_cpu_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    Reset = 1'b0;
    model_clear();
    chk_perf("rst2");
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 10'd6, '0, 1'b1, 1'b0, 10'd7, '0, gc, gd);
      chk($sformatf("post_rst%0d_dbg_gnt", i), smp_dg, i == 4);
    end

    // Randomised traffic, each requester holds its request until granted
    pc_req = 0; pd_req = 0; pc_we = 0; pd_we = 0; pc_a = 0; pd_a = 0; pc_d = 0; pd_d = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!pc_req && $urandom_range(0, 3) != 0) begin
        pc_req = 1; pc_we = $urandom_range(0, 1) == 1; pc_a = rnd_addr(); pc_d = $urandom;
      end
      if (!pd_req && $urandom_range(0, 2) == 0) begin
        pd_req = 1; pd_we = $urandom_range(0, 1) == 1; pd_a = rnd_addr(); pd_d = $urandom;
      end
      cyc(pc_req, pc_we, pc_a, pc_d, pd_req, pd_we, pd_a, pd_d, gc, gd);
      if (gc) pc_req = 0;
      if (gd) pd_req = 0;
    end
    cyc(1'b0, 1'b0, 10'd0, '0, 1'b0, 1'b0, 10'd0, '0, gc, gd);
    chk_perf("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
